bin2qdi_e1of2_bus: RTL and testbench
====================================

Name: bin2qdi_e1of2_bus

Overview:
- Clocked bridge from the synchronous verilog testbench/SoC side into QDI circuits.
- Accepts WIDTH-bit binary words through a valid/ready handshake and buffers them in a DEPTH-entry FIFO.
- Drives each word onto WIDTH parallel e1of2 channels that share one enable (Re), using a 4-phase return-to-zero handshake.
- Successor to the single-bit, unbuffered, event-driven source: it is multi-bit, buffered and clocked, with a synchronised enable.

Parameters:
- WIDTH, 8: number of data bits, which is also the number of dual-rail pairs.
- DEPTH, 4: FIFO entries; must be a power of 2 and at least 2.
- SYNC_STAGES, 2: flops in the Re synchroniser; must be at least 2.
- TIMEOUT, 1024: watchdog limit in cycles, used only with the optional feature.

Ports:
- CLK  input  1  system clock; everything except reset is on the rising edge.
- RESET  input  1  asynchronous, active-high reset.
- din  input  WIDTH  binary data word.
- din_valid  input  1  producer offers din.
- din_ready  output  1  FIFO can accept a word (not full and not in reset).
- R  output  2*WIDTH  e1of2 rails; pair i is R[2i+1:2i].
- Re  input  1  shared enable from the circuit; asynchronous, high means ready for data.
- count  output  $clog2(DEPTH)+1  FIFO occupancy.
- busy  output  1  high when the FIFO is non-empty or state is not IDLE.
- err  output  2  sticky error flags; tied to 0 unless the optional feature is compiled in.

Behaviour:
- Reset (asynchronous, active-high):
  - R=0, FIFO flushed, count=0, state=WAIT_EN, synchroniser cleared to 0, err=0.
  - din_ready=0 while RESET is high.
  - Reset mid-handshake returns the rails to neutral at once; any word on the rails is lost.
- Encoding per bit: 0 -> 01, 1 -> 10, i.e. R[2i+1:2i] = {d[i], ~d[i]}. The value 11 is never driven.
- R comes straight from a single register; all pairs change on the same edge. Transitions are only neutral->valid or valid->neutral, never valid->valid.
- Re is passed through SYNC_STAGES flops to give Re_s. All decisions below use Re_s.
- FIFO:
  - A write happens when din_valid && din_ready.
  - din_ready = !full && !RESET.
  - No bypass: a word always occupies the FIFO for at least one cycle.
  - A write and a pop in the same cycle leave count unchanged.
- States:
  - WAIT_EN (rails neutral): Re_s=1 -> IDLE.
  - IDLE (rails neutral, Re_s=1): FIFO non-empty -> pop the head, load the encoded word into R, go to DRIVE. An empty FIFO holds IDLE.
  - DRIVE (rails valid): Re_s=0 -> next edge R=0, go to WAIT_EN. Re_s=1 holds the data.
- Latency:
  - Word written at edge k into an empty FIFO while in IDLE: R is valid after edge k+1.
  - Re falling: R is neutral SYNC_STAGES+1 edges later.
  - Back-to-back throughput is one word per full handshake, at least 2*(SYNC_STAGES+1) cycles.
- Boundaries:
  - FIFO full: din_ready=0; din is ignored and nothing is overwritten.
  - Re_s low in IDLE (circuit reset) -> WAIT_EN without popping.
  - Re_s toggling high and back within DRIVE before any low is sampled is not seen; only the sampled value matters.
  - count never exceeds DEPTH and never wraps.

Optional Feature:
- Macro: BIN2QDI_CHECK_EN. When defined:
  - err[0] sets when the block stays in DRIVE or WAIT_EN for more than TIMEOUT consecutive cycles.
  - err[1] sets when Re_s falls while in IDLE. This is a protocol warning: the circuit withdrew enable with no data offered.
  - Each event also calls $display with "bin2qdi_e1of2_bus:" and %t.
  - Flags are sticky until RESET.
- When undefined: err=2'b00, no watchdog counter or check logic is built, and there is no $display.

Test Plan:
- Reset released, Re=1, write din=8'hA5 -> R=16'b1001_1001_0110_0110 one edge after the IDLE pop; count returns to 0.
- Re held 1, write 5 words back-to-back -> din_ready drops after 4 accepted (count=4); the 5th is held until the first pop; words appear on R in order.
- While R is valid, drop Re -> R=0 exactly SYNC_STAGES+1 edges later; raise Re -> the next word appears SYNC_STAGES+2 edges after the rise.
- Assert RESET while in DRIVE with 3 words queued -> R=0 and count=0 immediately; after release, no stale word is driven.
- Sweep din over 0, all-ones and 1-hot patterns -> no pair ever reads 11; each rail pair matches its bit.
- With BIN2QDI_CHECK_EN, hold Re=1 in DRIVE for TIMEOUT+1 cycles -> err=2'b01. Then drop Re in IDLE -> err=2'b11. Without the macro -> err=0.

Source files
------------

// File: rtl/bin2qdi_e1of2_bus_if.sv
// rtl/bin2qdi_e1of2_bus_if.sv - binary word input handshake and shared-enable e1of2 rail bundle
interface bin2qdi_e1of2_bus_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0]   din;
    logic               din_valid;
    logic               din_ready;
    logic [2*WIDTH-1:0] R;
    logic               Re;

    modport slave (
        input  din,
        input  din_valid,
        input  Re,
        output din_ready,
        output R
    );

    modport master (
        output din,
        output din_valid,
        output Re,
        input  din_ready,
        input  R
    );
endinterface

// File: rtl/bin2qdi_e1of2_bus.sv
// rtl/bin2qdi_e1of2_bus.sv - buffered clocked bridge from binary words to WIDTH e1of2 pairs with one shared enable
// Optional watchdog/protocol checks build only with BIN2QDI_CHECK_EN; otherwise err is tied to 2'b00.
module bin2qdi_e1of2_bus #(
    parameter int WIDTH       = 8,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 1024
) (
    input  logic                   CLK,
    input  logic                   RESET,
    bin2qdi_e1of2_bus_if.slave     bus,
    output logic [$clog2(DEPTH):0] count,
    output logic                   busy,
    output logic [1:0]             err
);
    localparam int AW = $clog2(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || SYNC_STAGES < 2 || TIMEOUT < 1) begin : g_bad_param
        $error("bin2qdi_e1of2_bus: illegal parameter set");
    end

    typedef enum logic [1:0] {
        WAIT_EN = 2'd0,
        IDLE    = 2'd1,
        DRIVE   = 2'd2
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] re_sync;
    logic                   re_s;
    logic [WIDTH-1:0]       mem [DEPTH];
    logic [AW-1:0]          wr_ptr;
    logic [AW-1:0]          rd_ptr;
    logic [2*WIDTH-1:0]     r_q;
    logic                   full;
    logic                   empty;
    logic                   wr;
    logic                   pop;

    function automatic logic [2*WIDTH-1:0] encode(input logic [WIDTH-1:0] d);
        logic [2*WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < WIDTH; i++) begin
            r[2*i+1] = d[i];
            r[2*i]   = ~d[i];
        end
        return r;
    endfunction

    assign re_s          = re_sync[SYNC_STAGES-1];
    assign full          = (count == (AW+1)'(DEPTH));
    assign empty         = (count == '0);
    assign bus.din_ready = !full && !RESET;
    assign wr            = bus.din_valid && bus.din_ready;
    // Pop only from IDLE, so a freshly written word always spends a cycle in the FIFO.
    assign pop           = (state == IDLE) && re_s && !empty;
    assign bus.R         = r_q;
    assign busy          = !empty || (state != IDLE);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            re_sync <= '0;
        end else begin
            re_sync <= {re_sync[SYNC_STAGES-2:0], bus.Re};
        end
    end

    always_ff @(posedge CLK) begin
        if (wr) begin
            mem[wr_ptr] <= bus.din;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Rails are a single register so every pair moves on the same edge.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= WAIT_EN;
            r_q   <= '0;
        end else begin
            case (state)
                WAIT_EN: begin
                    if (re_s) begin
                        state <= IDLE;
                    end
                end
                IDLE: begin
                    if (!re_s) begin
                        state <= WAIT_EN;
                    end else if (!empty) begin
                        r_q   <= encode(mem[rd_ptr]);
                        state <= DRIVE;
                    end
                end
                DRIVE: begin
                    if (!re_s) begin
                        r_q   <= '0;
                        state <= WAIT_EN;
                    end
                end
                default: begin
                    r_q   <= '0;
                    state <= WAIT_EN;
                end
            endcase
        end
    end

`ifdef BIN2QDI_CHECK_EN
    localparam int WDW = $clog2(TIMEOUT + 1) + 1;

    logic [WDW-1:0] wd_cnt;
    logic [1:0]     err_q;

    // Watchdog counts consecutive cycles away from IDLE; saturates at TIMEOUT.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            wd_cnt <= '0;
            err_q  <= 2'b00;
        end else begin
            if (state == IDLE) begin
                wd_cnt <= '0;
            end else if (wd_cnt != WDW'(TIMEOUT)) begin
                wd_cnt <= wd_cnt + 1'b1;
            end else if (!err_q[0]) begin
                err_q[0] <= 1'b1;
                $display("bin2qdi_e1of2_bus: handshake watchdog expired at %t", $time);
            end
            if (state == IDLE && !re_s && !err_q[1]) begin
                err_q[1] <= 1'b1;
                $display("bin2qdi_e1of2_bus: enable withdrawn in IDLE at %t", $time);
            end
        end
    end

    assign err = err_q;
`else
    assign err = 2'b00;
`endif

endmodule

// File: tb/tb_bin2qdi_e1of2_bus.sv
// tb/tb_bin2qdi_e1of2_bus.sv - scoreboard bench for bin2qdi_e1of2_bus
module tb_bin2qdi_e1of2_bus;
    localparam int W  = 8;
    localparam int D  = 4;
    localparam int SS = 2;
    localparam int TO = 1024;

    logic       CLK = 1'b0;
    logic       RESET;
    logic [2:0] count;
    logic       busy;
    logic [1:0] err;

    int total = 0;
    int bad   = 0;

    logic [2*W-1:0] exp_q [$];
    logic [2*W-1:0] prev_r = '0;
    bit             sender_done;

    bin2qdi_e1of2_bus_if #(.WIDTH(W)) bus ();

    bin2qdi_e1of2_bus #(
        .WIDTH(W), .DEPTH(D), .SYNC_STAGES(SS), .TIMEOUT(TO)
    ) dut (
        .CLK(CLK), .RESET(RESET), .bus(bus), .count(count), .busy(busy), .err(err)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [2*W-1:0] rails_of(input logic [W-1:0] d);
        logic [2*W-1:0] r;
        r = '0;
        for (int i = W - 1; i >= 0; i--) begin
            r = {r[2*W-3:0], (d[i] ? 2'b10 : 2'b01)};
        end
        return r;
    endfunction

    // Call at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic [W-1:0] w);
        int n;
        n = 0;
        bus.din       = w;
        bus.din_valid = 1'b1;
        while (!bus.din_ready && n < 200) begin
            @(negedge CLK);
            n++;
        end
        check("send_wait", (n < 200), 1);
        exp_q.push_back(rails_of(w));
        @(posedge CLK);
        @(negedge CLK);
        bus.din_valid = 1'b0;
    endtask

    task automatic re_cycle(input bit expect_next, output int fall_n, output int rise_n);
        @(negedge CLK);
        bus.Re = 1'b0;
        fall_n = 0;
        do begin
            @(posedge CLK);
            #1;
            fall_n++;
        end while (bus.R != '0 && fall_n < 20);
        check("fall_bound", (fall_n < 20), 1);
        @(negedge CLK);
        bus.Re = 1'b1;
        rise_n = 0;
        if (expect_next) begin
            do begin
                @(posedge CLK);
                #1;
                rise_n++;
            end while (bus.R == '0 && rise_n < 20);
            check("rise_bound", (rise_n < 20), 1);
        end else begin
            repeat (SS + 3) @(posedge CLK);
        end
        @(negedge CLK);
    endtask

    always @(negedge CLK) begin
        if (bus.R !== prev_r) begin
            logic any11;
            any11 = 1'b0;
            for (int i = 0; i < W; i++) begin
                if (bus.R[2*i+1] && bus.R[2*i]) any11 = 1'b1;
            end
            check("pair11", any11, 0);
            check("valid_to_valid", (prev_r != '0 && bus.R != '0), 0);
            if (prev_r == '0 && bus.R != '0) begin
                if (exp_q.size() == 0) check("unexpected_word", bus.R, 0);
                else check("word", bus.R, exp_q.pop_front());
            end
        end
        prev_r = bus.R;
    end

    initial begin
        int f, r, n;
        logic [W-1:0] pat;
        RESET         = 1'b1;
        bus.Re        = 1'b0;
        bus.din       = '0;
        bus.din_valid = 1'b0;
        repeat (3) @(negedge CLK);
        check("rst_R", bus.R, 0);
        check("rst_count", count, 0);
        check("rst_ready", bus.din_ready, 0);
        check("rst_err", err, 0);
        check("rst_busy", busy, 1);
        RESET  = 1'b0;
        bus.Re = 1'b1;
        repeat (6) @(negedge CLK);
        check("idle_busy", busy, 0);
        check("idle_ready", bus.din_ready, 1);

        // single word, one-edge latency after the IDLE pop
        send(8'hA5);
        check("a5_edge_k", bus.R, 0);
        @(negedge CLK);
        check("a5_R", bus.R, 16'b1001_1001_0110_0110);
        check("a5_count", count, 0);

        // five back-to-back words against a 4-deep FIFO
        sender_done = 1'b0;
        fork
            begin
                send(8'h11); send(8'h22); send(8'h33); send(8'h44); send(8'h55);
                sender_done = 1'b1;
            end
        join_none
        repeat (4) @(negedge CLK);
        check("full_count", count, 4);
        check("full_ready", bus.din_ready, 0);
        @(negedge CLK);
        check("full_hold", count, 4);
        re_cycle(1, f, r);
        check("fall_lat", f, SS + 1);
        check("rise_lat", r, SS + 2);
        for (int i = 0; i < 3; i++) re_cycle(1, f, r);
        re_cycle(1, f, r);
        n = 0;
        while (!sender_done && n < 100) begin
            @(negedge CLK);
            n++;
        end
        check("sender_done", sender_done, 1);
        re_cycle(0, f, r);
        check("burst_drained", exp_q.size(), 0);
        check("burst_count", count, 0);

        // reset in DRIVE with three words queued
        send(8'h01); send(8'h02); send(8'h03); send(8'h04);
        check("pre_rst_count", count, 3);
        check("pre_rst_drive", (bus.R != '0), 1);
        #2 RESET = 1'b1;
        #1;
        check("mid_rst_R", bus.R, 0);
        check("mid_rst_count", count, 0);
        check("mid_rst_ready", bus.din_ready, 0);
        exp_q.delete();
        @(negedge CLK);
        RESET = 1'b0;
        repeat (20) @(negedge CLK);
        check("post_rst_R", bus.R, 0);
        check("post_rst_count", count, 0);

        // encoding sweep: zero, all-ones, one-hot
        for (int i = 0; i < W + 2; i++) begin
            pat = (i == 0) ? '0 : (i == 1) ? '1 : W'(1) << (i - 2);
            send(pat);
            re_cycle(0, f, r);
        end
        check("sweep_drained", exp_q.size(), 0);

`ifdef BIN2QDI_CHECK_EN
        check("pre_err", err, 2'b00);
        send(8'h3C);
        repeat (TO + 5) @(negedge CLK);
        check("err_watchdog", err, 2'b01);
        re_cycle(0, f, r);
        bus.Re = 1'b0;
        repeat (SS + 3) @(negedge CLK);
        check("err_idle_drop", err, 2'b11);
        bus.Re = 1'b1;
        repeat (SS + 3) @(negedge CLK);
`else
        check("err_tied", err, 2'b00);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
